mem_stream_reader: RTL and testbench

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_rd_skid.sv | 66 ++++++
 rtl/mem_stream_reader.sv | 128 ++++++++++++
 tb/tb_mem_stream_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared widths, memory depth and FSM state encoding for the
//                memory stream reader.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int DATA_W     = 16;
    localparam int ADR_W      = 10;
    localparam int MEM_DEPTH  = 1024;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rd_skid
//  Description : Two-entry skid FIFO absorbing memory read data so that no
//                word is lost while the consumer stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_rd_skid
    import mem_pkg::*;
#(
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [SKID_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == 2'd2);
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule : mem_rd_skid
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stream_reader
//  Description : Reads a burst of consecutive words from a synchronous-read
//                memory and streams them out through a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stream_reader
    import mem_pkg::*;
#(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADR_W  = mem_pkg::ADR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [ADR_W:0]    length,
    output logic [ADR_W-1:0]  rd_adr,
    input  logic [DATA_W-1:0] mem_dat,
    output logic [DATA_W-1:0] dat_out,
    output logic              dat_valid,
    input  logic              dat_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADR_W:0]   c_max_len = {1'b1, {ADR_W{1'b0}}};
    localparam logic [ADR_W:0]   c_len_one = {{ADR_W{1'b0}}, 1'b1};
    localparam logic [ADR_W-1:0] c_adr_one = {{(ADR_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADR_W-1:0] r_rd_adr;
    logic [ADR_W:0]   r_remain;
    logic             r_inflight;

    logic [ADR_W:0]   w_len_clamped;
    logic [1:0]       w_count;
    logic [2:0]       w_occ;
    logic             w_pop;
    logic             w_issue;
    logic             w_accept_start;
    logic             w_drained;

    assign w_len_clamped  = (length > c_max_len) ? c_max_len : length;
    assign w_accept_start = (r_state == ST_IDLE) && start;
    assign w_pop          = dat_valid && dat_ready;

    // Occupancy after this cycle's pop: counting the departing head lets the
    // reader keep one word per cycle while still never overfilling the skid.
    assign w_occ     = ({1'b0, w_count} + {2'b00, r_inflight}) - {2'b00, w_pop};
    assign w_issue   = (r_state == ST_READ) && (w_occ < 3'd2);
    assign w_drained = (w_occ == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_len_clamped == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (w_issue && (r_remain == c_len_one)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A read issued this cycle returns on mem_dat next cycle; clearing the
    // in-flight flag on reset discards that returning word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_adr   <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept_start) begin
                r_rd_adr <= base_adr;
                r_remain <= w_len_clamped;
            end else if (w_issue) begin
                r_rd_adr <= r_rd_adr + c_adr_one;
                r_remain <= r_remain - c_len_one;
            end
        end
    end

    mem_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_inflight),
        .i_data  (mem_dat),
        .i_pop   (w_pop),
        .o_data  (dat_out),
        .o_valid (dat_valid),
        .o_count (w_count)
    );

    assign rd_adr = r_rd_adr;
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

endmodule : mem_stream_reader
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stream_reader
//  Description : Self-checking bench for mem_stream_reader with a preloaded
//                1024x16 synchronous-read memory and a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_adr;
    logic [10:0] length;
    logic [9:0]  rd_adr;
    logic [15:0] mem_dat;
    logic [15:0] dat_out;
    logic        dat_valid;
    logic        dat_ready;
    logic        busy;
    logic        done;

    logic [15:0] mem [1024];

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent burst, filled by do_burst.
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          adr_log[$];
    int          first_valid_t, done_t, done_cnt, stall_bad, post_valid;
    int          busy_cnt, last_acc_t;
    bit          timed_out;

    mem_stream_reader #(.DATA_W(16), .ADR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_adr  (base_adr),
        .length    (length),
        .rd_adr    (rd_adr),
        .mem_dat   (mem_dat),
        .dat_out   (dat_out),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dat <= mem[rd_adr];

    // Reference: a burst yields mem[(base+i) mod 1024] for i < min(len,1024).
    function automatic void build_expected(input int b, input int l);
        int n;
        exp_q.delete();
        n = (l > 1024) ? 1024 : l;
        for (int i = 0; i < n; i++) exp_q.push_back(16'(((b + i) % 1024) + 100));
    endfunction

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    // t counts cycles after the edge that samples start.
    task automatic do_burst(input int b, input int l, input int mode,
                            input int restart_t, input int budget);
        bit          prev_stall;
        logic [15:0] prev_dat;
        got.delete(); adr_log.delete();
        first_valid_t = -1; done_t = -1; done_cnt = 0; stall_bad = 0;
        post_valid = 0; busy_cnt = 0; last_acc_t = -1; timed_out = 1'b0;
        prev_stall = 1'b0; prev_dat = '0;
        @(negedge clk);
        start = 1'b1; base_adr = 10'(b); length = 11'(l); dat_ready = 1'b1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            start = (t == restart_t);
            if (t == restart_t) begin
                base_adr = 10'd500;
                length   = 11'd3;
            end
            case (mode)
                0:       dat_ready = 1'b1;
                1:       dat_ready = ((t % 3) == 0);
                default: dat_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            adr_log.push_back(int'(rd_adr));
            if (busy) busy_cnt++;
            if (prev_stall && (!dat_valid || dat_out !== prev_dat)) stall_bad++;
            if (done_t >= 0 && dat_valid) post_valid++;
            if (dat_valid && first_valid_t < 0) first_valid_t = t;
            if (dat_valid && dat_ready) begin
                got.push_back(dat_out);
                last_acc_t = t;
            end
            prev_stall = dat_valid && !dat_ready;
            prev_dat   = dat_out;
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        start = 1'b0;
        timed_out = (done_t < 0);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; dat_ready = 1'b0; base_adr = '0; length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (rd_adr !== 10'd0)   begin n_err++; $display("FAIL reset_rd_adr: got %0d expected 0", rd_adr); end
        n_cmp++; if (dat_out !== 16'd0)  begin n_err++; $display("FAIL reset_dat_out: got %0d expected 0", dat_out); end
        n_cmp++; if (dat_valid !== 1'b0) begin n_err++; $display("FAIL reset_dat_valid: got %0b expected 0", dat_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        do_burst(5, 4, 0, -1, 40);
        build_expected(5, 4);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout: got no done expected done"); end
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_word%0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (first_valid_t !== 2) begin n_err++; $display("FAIL basic_first_valid: got cycle %0d expected 2", first_valid_t); end
        n_cmp++; if (done_t !== 6) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected 6", done_t); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy_cnt !== 7) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 7", busy_cnt); end
    endtask

    task automatic test_wrap;
        do_burst(1022, 4, 0, -1, 40);
        build_expected(1022, 4);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL wrap_timeout: got no done expected done"); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (adr_log[i] !== ((1022 + i) % 1024)) begin n_err++; $display("FAIL wrap_rd_adr%0d: got %0d expected %0d", i, adr_log[i], (1022 + i) % 1024); end
        end
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL wrap_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_word%0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall;
        do_burst(0, 6, 1, -1, 80);
        build_expected(0, 6);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL stall_timeout: got no done expected done"); end
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL stall_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_word%0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_bad); end
        n_cmp++; if (done_t !== last_acc_t + 1) begin n_err++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_t, last_acc_t + 1); end
    endtask

    task automatic test_zero_len;
        do_burst(77, 0, 0, -1, 20);
        n_cmp++; if (first_valid_t !== -1) begin n_err++; $display("FAIL zero_valid: got valid at %0d expected none", first_valid_t); end
        n_cmp++; if (done_t !== 0) begin n_err++; $display("FAIL zero_done_cycle: got %0d expected 0", done_t); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
        n_cmp++; if (busy_cnt !== 1) begin n_err++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cnt); end
    endtask

    task automatic test_reset_mid_burst;
        int  acc;
        bit  bad;
        @(negedge clk);
        start = 1'b1; base_adr = 10'd0; length = 11'd8; dat_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int t = 0; t < 30 && acc < 2; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            if (dat_valid && dat_ready) acc++;
        end
        n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL rstmid_accepts: got %0d expected 2", acc); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        n_cmp++; if ({rd_adr, dat_out, dat_valid, busy, done} !== 29'd0) begin
            n_err++; $display("FAIL rstmid_outputs: got rd_adr=%0d dat_out=%0d valid=%0b busy=%0b done=%0b expected all 0",
                              rd_adr, dat_out, dat_valid, busy, done);
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            if (done || dat_valid || busy) bad = 1'b1;
        end
        n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet: got activity after reset expected none"); end
        do_burst(10, 2, 0, -1, 40);
        build_expected(10, 2);
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL rstmid_new_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_new_word%0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rstmid_new_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_restart_ignored;
        do_burst(200, 6, 0, 2, 60);
        build_expected(200, 6);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL restart_timeout: got no done expected done"); end
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL restart_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL restart_word%0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (adr_log[i] !== 200 + i) begin n_err++; $display("FAIL restart_rd_adr%0d: got %0d expected %0d", i, adr_log[i], 200 + i); end
        end
        n_cmp++; if (done_t !== 8) begin n_err++; $display("FAIL restart_done_cycle: got %0d expected 8", done_t); end
        n_cmp++; if (busy_cnt !== 9) begin n_err++; $display("FAIL restart_busy_cycles: got %0d expected 9", busy_cnt); end
    endtask

    task automatic test_random_bursts;
        int b, l;
        for (int k = 0; k < 6; k++) begin
            b = $urandom_range(0, 1023);
            l = $urandom_range(1, 24);
            do_burst(b, l, 2, -1, 400);
            build_expected(b, l);
            n_cmp++; if (timed_out) begin n_err++; $display("FAIL rand%0d_timeout: got no done expected done", k); end
            n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", k, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_word%0d: got %0d expected %0d", k, i, got[i], exp_q[i]); end
            end
            n_cmp++; if (first_valid_t !== 2) begin n_err++; $display("FAIL rand%0d_first_valid: got %0d expected 2", k, first_valid_t); end
            n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL rand%0d_hold: got %0d expected 0", k, stall_bad); end
            n_cmp++; if (post_valid !== 0) begin n_err++; $display("FAIL rand%0d_post_valid: got %0d expected 0", k, post_valid); end
            n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", k, done_cnt); end
            n_cmp++; if (done_t !== last_acc_t + 1) begin n_err++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", k, done_t, last_acc_t + 1); end
            n_cmp++; if (busy_cnt !== done_t + 1) begin n_err++; $display("FAIL rand%0d_busy_cycles: got %0d expected %0d", k, busy_cnt, done_t + 1); end
        end
        // Oversized length is clamped to a full-memory burst.
        b = $urandom_range(0, 1023);
        l = $urandom_range(1025, 2047);
        do_burst(b, l, 0, -1, 1100);
        build_expected(b, l);
        n_cmp++; if (got.size() !== 1024) begin n_err++; $display("FAIL clamp_count: got %0d expected 1024", got.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL clamp_word%0d: got %0d expected %0d", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (done_t !== 1026) begin n_err++; $display("FAIL clamp_done_cycle: got %0d expected 1026", done_t); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 100);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_reset_mid_burst();
        test_restart_ignored();
        test_random_bursts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_stream_reader
`default_nettype wire
